// File: rtl/rv32i_lsu_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_lsu_pkg
// Shared definitions for the RV32I memory-stage load/store unit:
//   - lsu_state_t   : FSM states IDLE -> BUS -> RESP
//   - F3_*          : RV32I funct3 size/sign encodings for loads and stores
//   - BE_*          : byte-lane mask constants
//   - helpers       : funct3 legality, byte-enable generation, store lane fill
// -----------------------------------------------------------------------------
package rv32i_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic f3_supported(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: f3_supported = 1'b1;
      default:                             f3_supported = 1'b0;
    endcase
  endfunction

  // funct3[1:0] carries the access size for both signed and unsigned forms.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   byte_enables = BE_BYTE << a;
      2'b01:   byte_enables = a[1] ? BE_HALF_HI : BE_HALF_LO;
      default: byte_enables = BE_WORD;
    endcase
  endfunction

  // Replicate store data across all lanes so the byte enables alone select it.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// -----------------------------------------------------------------------------
// rv32i_load_align
// Combinational load-data extraction: selects the addressed byte/half/word of
// the bus read word and sign- or zero-extends it.
// Ports:
//   i_rdata   [31:0]  raw read word from the data bus
//   i_addr_lo [1:0]   low byte-address bits of the access
//   i_funct3  [2:0]   RV32I load funct3 (LB/LH/LW/LBU/LHU)
//   o_data    [31:0]  extended load result (0 for unsupported funct3)
// -----------------------------------------------------------------------------
module rv32i_load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword select uses addr[1] only, so an odd address is forced aligned.
  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_rdata;
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_load_store_unit.sv
// -----------------------------------------------------------------------------
// rv32i_load_store_unit
// Memory-stage load/store unit. Takes one request from EX/MEM, runs a single
// req/ack bus transfer, stalls the pipeline until the ack, and returns the
// extended load result, registered, toward the write-back mux.
//
// Handshake: o_mem_req rises one cycle after the request is captured and, with
// all other bus outputs, stays stable until the cycle in which i_mem_ack=1; the
// transfer completes on that rising edge and i_mem_rdata is sampled there.
// i_mem_ack is ignored whenever o_mem_req is low.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req/i_we/i_funct3     request, store flag, size/sign field
//   i_addr/i_wdata          byte address, store data (rs2)
//   o_stall                 freeze PC/IF/ID/EX/MEM
//   o_load_data/valid       extended load result, one-cycle new-data pulse
//   o_mem_*                 data bus request side (word address, lanes, be)
//   i_mem_ack/i_mem_rdata   data bus completion and read word
//   o_misaligned            only with RV32I_LSU_MISALIGN_TRAP_EN defined
//
// Configuration: defining RV32I_LSU_MISALIGN_TRAP_EN traps misaligned H/W
// accesses (no bus cycle, o_misaligned pulse); otherwise the low address bits
// below the access size are ignored.
// -----------------------------------------------------------------------------
module rv32i_load_store_unit
  import rv32i_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_stall,
  output logic [XLEN-1:0]   o_load_data,
  output logic              o_load_valid,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic              i_mem_ack,
  input  logic [XLEN-1:0]   i_mem_rdata
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  ,
  output logic              o_misaligned
`endif
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [XLEN-1:0]   r_load_data;
  logic              r_load_valid;
  logic [XLEN-1:0]   w_align_data;
  logic              w_supported;
  logic              w_misaligned;
  logic              w_to_bus;

  assign w_supported = f3_supported(i_funct3);

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  logic r_misaligned;
  assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  assign o_misaligned = r_misaligned;
`else
  assign w_misaligned = 1'b0;
`endif

  // Unsupported or trapped requests skip the bus and finish in RESP.
  assign w_to_bus = w_supported && !w_misaligned;

  rv32i_load_align u_align (
    .i_rdata   (i_mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_align_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_stall = 1'b0;
    case (r_state)
      IDLE: begin
        o_stall = i_req;
        if (i_req) w_next = w_to_bus ? BUS : RESP;
      end
      BUS: begin
        o_stall = 1'b1;
        if (i_mem_ack) w_next = RESP;
      end
      // The finished instruction still sits in MEM here, so i_req is ignored.
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= 4'b0000;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_load_valid <= 1'b0;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_funct3  <= i_funct3;
            r_addr_lo <= i_addr[1:0];
            if (w_to_bus) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_we;
              r_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= store_lanes(i_funct3, i_wdata);
              r_mem_be    <= byte_enables(i_funct3, i_addr[1:0]);
            end else if (!w_supported && !i_we) begin
              r_load_data  <= '0;
              r_load_valid <= 1'b1;
            end
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
            if (w_supported && w_misaligned) r_misaligned <= 1'b1;
`endif
          end
        end
        BUS: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (!r_mem_we) begin
              r_load_data  <= w_align_data;
              r_load_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_be     = r_mem_be;
  assign o_load_data  = r_load_data;
  assign o_load_valid = r_load_valid;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_rv32i_load_store_unit
// Self-checking bench: directed vector table, reset/ack corner sequences and
// randomized transactions checked against a specification-level model.
// -----------------------------------------------------------------------------
module tb_rv32i_load_store_unit;

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_bus;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
    logic        exp_valid;
    int          exp_stall;
    logic        exp_mis;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic [31:0] o_load_data;
  logic        o_load_valid;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        w_mis;

  always #5 i_clk = ~i_clk;

  rv32i_load_store_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_stall      (o_stall),
    .o_load_data  (o_load_data),
    .o_load_valid (o_load_valid),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata)
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    ,
    .o_misaligned (w_mis)
`endif
  );

`ifndef RV32I_LSU_MISALIGN_TRAP_EN
  assign w_mis = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_ld;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(logic [31:0] rdata, logic [31:0] addr, logic [2:0] f3);
    logic [31:0] b_v, h_v;
    int unsigned off;
    off = addr % 4;
    b_v = (rdata >> (8 * off)) & 32'hFF;
    h_v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b_v >= 128)   ? b_v - 32'd256   : b_v;
      3'd1:    return (h_v >= 32768) ? h_v - 32'd65536 : h_v;
      3'd2:    return rdata;
      3'd4:    return b_v;
      3'd5:    return h_v;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(logic [2:0] f3, logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    case (f3 % 4)
      0:       return 4'(1 << off);
      1:       return 4'(3 << (2 * (off / 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] d);
    case (f3 % 4)
      0:       return (d & 32'hFF) * 32'h01010101;
      1:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int waits, logic bus, logic [3:0] be,
                              logic [31:0] ewd, logic [31:0] eld, logic valid, int stall,
                              logic mis);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.waits = waits; v.exp_bus = bus; v.exp_be = be; v.exp_wdata = ewd;
    v.exp_ld = eld; v.exp_valid = valid; v.exp_stall = stall; v.exp_mis = mis;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    logic        we, sup, mis, bus;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd;
    int          waits, sel, size;
    we  = 1'($urandom_range(0, 1));
    sel = we ? $urandom_range(0, 3) : $urandom_range(0, 5);
    case (sel)
      0: f3 = 3'd0;
      1: f3 = 3'd1;
      2: f3 = 3'd2;
      3: f3 = we ? 3'd3 : 3'd4;
      4: f3 = 3'd5;
      default: f3 = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
    endcase
    if (we && sel == 3) f3 = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd7;
    addr  = $urandom;
    wd    = $urandom;
    rd    = $urandom;
    waits = $urandom_range(0, 3);
    sup   = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    size  = f3 % 4;
    mis   = FEAT && sup && ((size == 1 && addr % 2 == 1) || (size == 2 && addr % 4 != 0));
    bus   = sup && !mis;
    return mk(we, f3, addr, wd, rd, waits, bus, ref_be(f3, addr), ref_wdata(f3, wd),
              ref_load(rd, addr, f3), !we && !mis, bus ? 2 + waits : 1, mis);
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge with the DUT in IDLE; returns one cycle
  // after the RESP cycle with i_req dropped.
  task automatic run_txn(input vec_t v, input string tag);
    int          stall_cnt, bus_cnt;
    logic        done, got_valid, got_mis, early_valid;
    logic [31:0] got_ld;
    i_req = 1'b1; i_we = v.we; i_funct3 = v.f3; i_addr = v.addr; i_wdata = v.wdata;
    i_mem_ack = 1'b0; i_mem_rdata = $urandom;
    stall_cnt = 0; bus_cnt = 0; done = 1'b0; got_valid = 1'b0; got_mis = 1'b0;
    got_ld = '0; early_valid = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (o_mem_req) begin
        bus_cnt++;
        check({tag, "_addr"}, o_mem_addr, {v.addr[31:2], 2'b00});
        check({tag, "_we"}, 32'(o_mem_we), 32'(v.we));
        check({tag, "_be"}, 32'(o_mem_be), 32'(v.exp_be));
        if (v.we) check({tag, "_wdata"}, o_mem_wdata, v.exp_wdata);
        if (bus_cnt > v.waits) begin
          i_mem_ack = 1'b1; i_mem_rdata = v.rdata;
        end else begin
          i_mem_ack = 1'b0; i_mem_rdata = $urandom;
        end
      end else begin
        i_mem_ack = 1'b0;
      end
      if (o_stall) begin
        stall_cnt++;
        if (o_load_valid || w_mis) early_valid = 1'b1;
      end else begin
        done      = 1'b1;
        got_valid = o_load_valid;
        got_ld    = o_load_data;
        got_mis   = w_mis;
        // An ack in RESP must have no effect.
        i_mem_ack = 1'b1; i_mem_rdata = $urandom;
      end
      @(negedge i_clk);
    end
    i_req = 1'b0; i_mem_ack = 1'b0;
    if (!done) check({tag, "_timeout"}, 32'd1, 32'd0);
    check({tag, "_stall"}, 32'(stall_cnt), 32'(v.exp_stall));
    check({tag, "_buscycles"}, 32'(bus_cnt), v.exp_bus ? 32'(v.waits + 1) : 32'd0);
    check({tag, "_early"}, 32'(early_valid), 32'd0);
    check({tag, "_valid"}, 32'(got_valid), 32'(v.exp_valid));
    check({tag, "_mis"}, 32'(got_mis), 32'(v.exp_mis));
    if (v.exp_valid) exp_q.push_back(v.exp_ld);
    else             exp_q.push_back(model_ld);
    model_ld = exp_q.pop_front();
    check({tag, "_ld"}, got_ld, model_ld);
    #1;
    check({tag, "_post_valid"}, 32'(o_load_valid), 32'd0);
    check({tag, "_post_mis"}, 32'(w_mis), 32'd0);
    check({tag, "_post_ld"}, o_load_data, model_ld);
  endtask

  // ---------------- test ----------------
  vec_t tbl[$];

  initial begin
    // Directed table: aligned cases valid in both configurations.
    tbl.push_back(mk(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 1, 4'hF, 0, 32'hDEADBEEF, 1, 2, 0));
    tbl.push_back(mk(0, 3'd0, 32'h103, 0, 32'h80112233, 0, 1, 4'h8, 0, 32'hFFFFFF80, 1, 2, 0));
    tbl.push_back(mk(0, 3'd4, 32'h103, 0, 32'h80112233, 0, 1, 4'h8, 0, 32'h00000080, 1, 2, 0));
    tbl.push_back(mk(1, 3'd1, 32'h202, 32'h1234ABCD, 0, 3, 1, 4'hC, 32'hABCDABCD, 0, 0, 5, 0));
    tbl.push_back(mk(0, 3'd2, 32'h004, 0, 32'h11223344, 0, 1, 4'hF, 0, 32'h11223344, 1, 2, 0));
    tbl.push_back(mk(0, 3'd5, 32'h006, 0, 32'hBEEF0000, 0, 1, 4'hC, 0, 32'h0000BEEF, 1, 2, 0));
    tbl.push_back(mk(0, 3'd1, 32'h002, 0, 32'h80010000, 1, 1, 4'hC, 0, 32'hFFFF8001, 1, 3, 0));
    tbl.push_back(mk(1, 3'd0, 32'h011, 32'h000000A5, 0, 0, 1, 4'h2, 32'hA5A5A5A5, 0, 0, 2, 0));
    tbl.push_back(mk(0, 3'd0, 32'h010, 0, 32'h0000007F, 0, 1, 4'h1, 0, 32'h0000007F, 1, 2, 0));
    tbl.push_back(mk(0, 3'd3, 32'h040, 0, 32'h55555555, 0, 0, 4'h0, 0, 32'h00000000, 1, 1, 0));
    tbl.push_back(mk(1, 3'd2, 32'h300, 32'hCAFEF00D, 0, 2, 1, 4'hF, 32'hCAFEF00D, 0, 0, 4, 0));
    tbl.push_back(mk(1, 3'd7, 32'h304, 32'h12345678, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0));
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 3'd2, 32'h104, 0, 32'h01020304, 0, 1, 4'hF, 0, 32'h01020304, 1, 2, 0));
    tbl.push_back(mk(0, 3'd2, 32'h101, 0, 32'h99999999, 0, 0, 4'h0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 3'd1, 32'h003, 0, 32'h99999999, 0, 0, 4'h0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 3'd5, 32'h001, 0, 32'h99999999, 0, 0, 4'h0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 3'd2, 32'h102, 32'h77777777, 0, 0, 0, 4'h0, 0, 0, 0, 1, 1));
`else
    tbl.push_back(mk(0, 3'd2, 32'h0FF, 0, 32'h01020304, 0, 1, 4'hF, 0, 32'h01020304, 1, 2, 0));
    tbl.push_back(mk(0, 3'd1, 32'h001, 0, 32'h1234F00D, 0, 1, 4'h3, 0, 32'hFFFFF00D, 1, 2, 0));
    tbl.push_back(mk(0, 3'd5, 32'h003, 0, 32'h9ABC5678, 1, 1, 4'hC, 0, 32'h00009ABC, 1, 3, 0));
    tbl.push_back(mk(1, 3'd2, 32'h102, 32'h77777777, 0, 0, 1, 4'hF, 32'h77777777, 0, 0, 2, 0));
`endif

    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'd0; i_addr = '0; i_wdata = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0; model_ld = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_mem_we", 32'(o_mem_we), 32'd0);
    check("rst_load_valid", 32'(o_load_valid), 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_mem_wdata", o_mem_wdata, 32'd0);
    check("rst_load_data", o_load_data, 32'd0);
    check("rst_mem_be", 32'(o_mem_be), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_mis", 32'(w_mis), 32'd0);

    // Acks while idle must be ignored.
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge i_clk); #1;
      check("idle_ack_req", 32'(o_mem_req), 32'd0);
      check("idle_ack_valid", 32'(o_load_valid), 32'd0);
    end
    i_mem_ack = 1'b0;

    // Directed table; consecutive entries run back-to-back.
    foreach (tbl[k]) run_txn(tbl[k], $sformatf("vec%0d", k));

    // Reset while in BUS; the ack that follows must be ignored.
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h500; i_wdata = '0;
    i_mem_ack = 1'b0;
    #1;
    check("mrst_stall_idle", 32'(o_stall), 32'd1);
    @(negedge i_clk); #1;
    check("mrst_req_bus", 32'(o_mem_req), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; i_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h13572468;
    #1;
    check("mrst_req", 32'(o_mem_req), 32'd0);
    check("mrst_stall", 32'(o_stall), 32'd0);
    check("mrst_ld", o_load_data, 32'd0);
    repeat (2) begin
      @(negedge i_clk); #1;
      check("mrst_late_ack_valid", 32'(o_load_valid), 32'd0);
      check("mrst_late_ack_req", 32'(o_mem_req), 32'd0);
    end
    i_mem_ack = 1'b0;
    model_ld = '0;
    @(negedge i_clk); #1;

    // Randomized transactions against the model.
    for (int r = 0; r < 200; r++) run_txn(rand_vec(), $sformatf("rnd%0d", r));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
